// File: rtl/nc_arb_pkg.sv
// Shared definitions for the grant arbiters: FSM states, counter widths and
// default parameter values.
package nc_arb_pkg;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_GRANTS_PER_REQ = 3;
  localparam int unsigned DEF_GAP_CYCLES     = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_GAP     = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Width of a counter that must hold the values 0..grants.
  function automatic int unsigned grant_cnt_w(input int unsigned grants);
    return $clog2(grants + 1);
  endfunction

  // Width of a counter that must hold the values 0..gap.
  function automatic int unsigned gap_cnt_w(input int unsigned gap);
    return $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/nc_grant_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit at or
// after the pointer, wrapping from N-1 back to 0.
module rr_pick
  import nc_arb_pkg::*;
#(
  parameter int unsigned N  = DEF_NUM_REQ,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // Scan candidates in priority order ptr, ptr+1, ... and keep the first hit.
  // ptr < N and offset < N, so one conditional subtraction gives the modulo.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(off);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_cand = w_sum[IW-1:0];
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/nc_grant_arbiter.sv
// Round-robin arbiter that hands the shared resource to one requester for a
// tenure of GRANTS_PER_REQ single-cycle grant pulses spaced by GAP_CYCLES idle
// cycles, then requires the owner to drop its request.
//
// Handshake: req[i] is a level held for the whole tenure. gnt[i] is a
// registered one-cycle pulse; each pulse is one grant. The owner must keep
// req[i] high up to and including the edge of its last grant and must have it
// low on the next edge. Dropping early aborts the tenure; holding late flags
// err once and the arbiter waits for the drop.
module nc_grant_arbiter
  import nc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned GRANTS_PER_REQ = DEF_GRANTS_PER_REQ,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       done,
  output logic                       abort,
  output logic                       err,
  output arb_state_e                 dbg_state
);

  localparam int unsigned OW  = $clog2(NUM_REQ);
  localparam int unsigned GCW = grant_cnt_w(GRANTS_PER_REQ);
  localparam int unsigned PCW = gap_cnt_w(GAP_CYCLES);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("NUM_REQ must be at least 2");
  end
  if (GRANTS_PER_REQ < 1) begin : g_bad_grants
    $error("GRANTS_PER_REQ must be at least 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 1");
  end

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [OW-1:0]      r_owner;
  logic [OW-1:0]      r_ptr;
  logic               r_busy;
  logic               r_done;
  logic               r_abort;
  logic               r_err;
  logic               r_err_sent;
  logic [GCW-1:0]     r_grant_cnt;
  logic [PCW-1:0]     r_gap_cnt;

  arb_state_e         w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [OW-1:0]      w_owner_nxt;
  logic [OW-1:0]      w_ptr_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_abort_nxt;
  logic               w_err_nxt;
  logic               w_err_sent_nxt;
  logic [GCW-1:0]     w_grant_cnt_nxt;
  logic [PCW-1:0]     w_gap_cnt_nxt;

  logic               w_pick_valid;
  logic [OW-1:0]      w_pick_idx;
  logic               w_req_own;
  logic [OW-1:0]      w_ptr_after_owner;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_rr_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_req_own         = req[r_owner];
  assign w_ptr_after_owner = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + OW'(1);

  // Next-state and next-output logic. Any path that ends a tenure returns
  // owner to 0; the owner's req is checked first so an early drop beats the
  // grant and gap counters.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = '0;
    w_owner_nxt     = r_owner;
    w_ptr_nxt       = r_ptr;
    w_done_nxt      = 1'b0;
    w_abort_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_sent_nxt  = r_err_sent;
    w_grant_cnt_nxt = r_grant_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    unique case (r_state)
      ST_IDLE: begin
        w_owner_nxt = '0;
        if (w_pick_valid) begin
          w_state_nxt     = ST_GRANT;
          w_owner_nxt     = w_pick_idx;
          w_gnt_nxt       = NUM_REQ'(1) << w_pick_idx;
          w_grant_cnt_nxt = '0;
          w_err_sent_nxt  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!w_req_own) begin
          w_abort_nxt = 1'b1;
          w_ptr_nxt   = w_ptr_after_owner;
          w_owner_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_grant_cnt_nxt = r_grant_cnt + GCW'(1);
          if (r_grant_cnt + GCW'(1) == GCW'(GRANTS_PER_REQ)) begin
            w_state_nxt = ST_RELEASE;
          end else begin
            w_gap_cnt_nxt = PCW'(GAP_CYCLES);
            w_state_nxt   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (!w_req_own) begin
          w_abort_nxt = 1'b1;
          w_ptr_nxt   = w_ptr_after_owner;
          w_owner_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_gap_cnt == PCW'(1)) begin
          w_gnt_nxt   = NUM_REQ'(1) << r_owner;
          w_state_nxt = ST_GRANT;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - PCW'(1);
        end
      end
      ST_RELEASE: begin
        if (!w_req_own) begin
          // A late release already reported err; it never also reports done.
          w_done_nxt  = !r_err_sent;
          w_ptr_nxt   = w_ptr_after_owner;
          w_owner_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (!r_err_sent) begin
          w_err_nxt      = 1'b1;
          w_err_sent_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers; reset abandons any tenure without pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_err       <= 1'b0;
      r_err_sent  <= 1'b0;
      r_grant_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_owner     <= w_owner_nxt;
      r_ptr       <= w_ptr_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_abort     <= w_abort_nxt;
      r_err       <= w_err_nxt;
      r_err_sent  <= w_err_sent_nxt;
      r_grant_cnt <= w_grant_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign owner     = r_owner;
  assign busy      = r_busy;
  assign done      = r_done;
  assign abort     = r_abort;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nc_grant_arbiter.sv
// Bench for nc_grant_arbiter (4 requesters, 3 grants, 1 gap cycle): a table of
// basic-tenure vectors, hand-written corner sequences, and random traffic,
// all also compared every cycle against a tenure-schedule reference model.
module tb_nc_grant_arbiter;
  import nc_arb_pkg::*;

  localparam int N     = 4;
  localparam int G     = 3;
  localparam int P     = 1;
  localparam int OW    = 2;
  localparam int L_OFF = 1 + (G - 1) * (P + 1); // edge offset of the last grant
  localparam int OUT_W = N + OW + 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic [OW-1:0] owner;
  logic          busy, done, abort, err;
  arb_state_e    dbg_state;

  always #5 clk = ~clk;

  nc_grant_arbiter #(
    .NUM_REQ        (N),
    .GRANTS_PER_REQ (G),
    .GAP_CYCLES     (P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .done      (done),
    .abort     (abort),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [OUT_W-1:0] exp_q[$];

  // Output word layout: {gnt[3:0], owner[1:0], busy, done, abort, err}
  function automatic logic [OUT_W-1:0] pack(input logic [N-1:0] g, input logic [OW-1:0] o,
                                            input logic b, input logic d, input logic a,
                                            input logic e);
    return {g, o, b, d, a, e};
  endfunction

  function automatic logic bit_of(input logic [N-1:0] v, input int idx);
    return |(v & (N'(1) << idx));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks a tenure as "edges since the winning pick": grants fall on offsets
  // 1, 1+(P+1), ... up to L_OFF; any later offset is the release window.
  bit            m_active   = 1'b0;
  int            m_k        = 0;
  int            m_owner    = 0;
  int            m_ptr      = 0;
  bit            m_err_sent = 1'b0;
  logic [N-1:0]  e_gnt;
  logic [OW-1:0] e_owner;
  logic          e_busy, e_done, e_abort, e_err;

  task automatic model_step();
    bit found;
    e_done = 1'b0; e_abort = 1'b0; e_err = 1'b0;
    e_gnt = '0; e_owner = '0; e_busy = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_ptr    = 0;
    end else if (!m_active) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && bit_of(req, (m_ptr + i) % N)) begin
          found      = 1'b1;
          m_active   = 1'b1;
          m_owner    = (m_ptr + i) % N;
          m_k        = 0;
          m_err_sent = 1'b0;
        end
      end
      if (found) begin
        e_gnt   = N'(1) << m_owner;
        e_owner = OW'(m_owner);
        e_busy  = 1'b1;
      end
    end else begin
      m_k++;
      if (!bit_of(req, m_owner)) begin
        if (m_k <= L_OFF) e_abort = 1'b1;
        else if (!m_err_sent) e_done = 1'b1;
        m_active = 1'b0;
        m_ptr    = (m_owner + 1) % N;
      end else begin
        e_busy  = 1'b1;
        e_owner = OW'(m_owner);
        if ((m_k + 1 <= L_OFF) && ((m_k % (P + 1)) == 0)) e_gnt = N'(1) << m_owner;
        if (m_k > L_OFF && !m_err_sent) begin
          e_err      = 1'b1;
          m_err_sent = 1'b1;
        end
      end
    end
    exp_q.push_back(pack(e_gnt, e_owner, e_busy, e_done, e_abort, e_err));
  endtask

  // ---------------- driver ----------------
  // Apply inputs, clock one edge, sample outputs 1 time unit after it.
  task automatic step(input logic r, input logic [N-1:0] q, output logic [OUT_W-1:0] act);
    rst = r;
    req = q;
    @(posedge clk);
    model_step();
    #1;
    act = pack(gnt, owner, busy, done, abort, err);
    check("model", 32'(act), 32'(exp_q.pop_front()));
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic             r;
    logic [N-1:0]     q;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [OUT_W-1:0] act;
    logic [N-1:0]     q;
    int               n, off;

    // Basic tenure for requester 0: grants at edges 1,3,5, done seen at 7.
    tbl[0] = '{1'b0, 4'b0001, pack(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[1] = '{1'b0, 4'b0001, pack(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[2] = '{1'b0, 4'b0001, pack(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[3] = '{1'b0, 4'b0001, pack(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[4] = '{1'b0, 4'b0001, pack(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[5] = '{1'b0, 4'b0001, pack(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[6] = '{1'b0, 4'b0000, pack(4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[7] = '{1'b0, 4'b0000, pack(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};

    // Reset state.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1111, act);
      check("reset", 32'(act), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].q, act);
      check("basic", 32'(act), 32'(tbl[i].exp));
    end

    // Late release by requester 1 (pointer is 1): err once, never done.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i <= 8) ? 4'b0010 : 4'b0000, act);
      check("late_gnt", 32'(act[9:6]), (i == 0 || i == 2 || i == 4) ? 32'h2 : 32'h0);
      check("late_err", 32'(act[0]), 32'(i == 6));
      check("late_done", 32'(act[2]), 32'd0);
      if (i == 8) check("late_busy_hold", 32'(act[3]), 32'd1);
      if (i == 9) check("late_busy_end", 32'(act[3]), 32'd0);
    end

    // Early drop during the gap (pointer is 2): only the first grant.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i <= 1) ? 4'b0100 : 4'b0000, act);
      check("gapab_gnt", 32'(act[9:6]), (i == 0) ? 32'h4 : 32'h0);
      check("gapab_abort", 32'(act[1]), 32'(i == 2));
    end

    // Early drop while the second grant is out (pointer 3, wraps to 2).
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i <= 2) ? 4'b0100 : 4'b0000, act);
      check("grab_gnt", 32'(act[9:6]), (i == 0 || i == 2) ? 32'h4 : 32'h0);
      check("grab_abort", 32'(act[1]), 32'(i == 3));
      check("grab_done", 32'(act[2]), 32'd0);
    end

    // Rotation with all four requesting; each owner drops right after its
    // last grant and re-requests on the following edge.
    step(1'b1, 4'b0000, act);
    for (int e = 0; e < 35; e++) begin
      n   = e / 7;
      off = e % 7;
      q   = 4'b1111;
      if (off == 6) q = q & ~(N'(1) << (n % N));
      step(1'b0, q, act);
      if (off == 0) check("rot_owner", 32'(act[5:4]), 32'(n % N));
      check("rot_gnt", 32'(act[9:6]),
            (off == 0 || off == 2 || off == 4) ? 32'(N'(1) << (n % N)) : 32'd0);
      check("rot_done", 32'(act[2]), 32'(off == 6));
    end

    // Reset in the middle of requester 3's tenure, then re-arbitrate.
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 6) q = 4'b1000;
      else if (i >= 7) q = 4'b1001;
      else q = 4'b1000;
      step(i == 4 || i == 6, q, act);
      if (i == 0) check("rst_first_gnt", 32'(act), 32'(pack(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0)));
      if (i == 4 || i == 6) check("rst_mid", 32'(act), 32'd0);
      if (i == 5) check("rst_regrant", 32'(act), 32'(pack(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0)));
      // Pointer must be back at 0, so requester 0 beats requester 3.
      if (i == 7) check("rst_ptr", 32'(act), 32'(pack(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
    end

    // Random traffic: requests toggle occasionally, rare resets.
    q = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) q = q ^ (N'(1) << b);
      end
      step($urandom_range(0, 99) == 0, q, act);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
